jacobi_feed_ctrl: RTL and testbench
===================================

# jacobi_feed_ctrl

Sequencing controller for the Y/V multiplier feed stage of the Jacobi solver. It streams packed 256-bit Y words (four 64-bit lanes: 16-bit column info plus a 48-bit value) from the Y SRAM. It uses each lane's column info to fetch the matching 48-bit V value from the V SRAM. It then presents a Y word and four V values to the feed datapath with a one-cycle load pulse every 4 cycles, so the datapath's 4-lane shift register is never starved. It also handles stream start, EOF/overrun termination, and pipeline drain.

## Interface
- Y_ADDR_W, 10, Y SRAM address width
- V_ADDR_W, 10, V SRAM address width (≤15); V address = col_info[V_ADDR_W-1:0]
- DRAIN_CYCLES, 12, cycles `feed_enable` stays high after the last load pulse

Ports:
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin a pass; sampled only in IDLE
- y_base  in  Y_ADDR_W  first Y word address
- y_len  in  Y_ADDR_W  max Y words to read (≥1)
- y_rd_en  out  1  Y SRAM read strobe
- y_rd_addr  out  Y_ADDR_W  Y SRAM address
- y_rd_data  in  256  Y SRAM data, valid the cycle after `y_rd_en`
- v_rd_en  out  1  V SRAM read strobe
- v_rd_addr  out  V_ADDR_W  V SRAM address
- v_rd_data  in  48  V SRAM data, valid the cycle after `v_rd_en`
- y_word  out  256  Y word to datapath `Yin`
- v_value_1..v_value_4  out  48 each  V values, lane 1 = `y_word[255:192]`
- fifo_switch  out  1  one-cycle load pulse (datapath `switch_from_fifo1_fifo2`)
- feed_enable  out  1  datapath enable; low holds the datapath cleared
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of pass
- overrun  out  1  sticky: `y_len` exhausted without EOF; cleared on accepted `start`

## Operation
- Lane k (k=0..3) is `word[255-64k -: 64]`; col_info is `lane[63:48]`.
- Lane classes are tested in priority order:
  - EOF: `lane[63:61]==3'b111` and `lane[60:0]==0`.
  - Diagonal: col_info[15]=1.
  - Else normal.
- EOF word: any lane is EOF. That lane and all later lanes of the word are treated as EOF lanes.
- V value per lane:
  - Normal lane: one V read, returned data goes to that lane's v_value.
  - Diagonal or EOF lane: no V read, v_value = 48'h0.
- FSM states: IDLE, PRIME, FILL, RUN, DRAIN.
  - IDLE: all outputs at reset values. `start` → PRIME; clear `overrun`; latch `y_base` and `y_len`.
  - PRIME (1 cycle): `y_rd_en`=1, `y_rd_addr`=base; `feed_enable`=1 from here until DRAIN exits.
  - FILL (1 cycle): `y_stage` <= `y_rd_data` → RUN, ph=0.
  - RUN: 4-cycle windows, ph 0..3.
    - At ph k: issue the V read for lane k of `y_stage` (if normal); returned data fills `v_buf[k]`.
    - At ph2: issue the Y read for the next word (address +1) unless `y_stage` is an EOF word or `y_len` words have already been read.
    - At the end of ph3: `y_cur` <= `y_stage`, `y_stage` <= `y_rd_data`.
    - At the end of ph0 of every window except the first: `y_word` <= `y_cur`, `v_value_1..3` <= `v_buf[0..2]`, `v_value_4` <= lane-3 value (live `v_rd_data` or 0), `fifo_switch` <= 1.
    - The final group is the EOF word, or the `y_len`-th word; the latter sets `overrun`. After the final group's load is issued → DRAIN.
  - DRAIN: count DRAIN_CYCLES; in the last cycle `done`=1; then → IDLE (`feed_enable`=0).
- `start` while busy: ignored.
- `reset` asserted in any state: next cycle all registers and outputs at reset values, state IDLE.

## Timing
- Reset values: all outputs 0, including `y_word`, `v_value_*`, `feed_enable`, and `overrun`.
- Cycle numbering: `start` sampled in cycle 0.
  - PRIME is cycle 1: `y_rd_en`.
  - FILL is cycle 2.
  - First RUN window is cycles 3-6: V reads for lanes 0-3 in cycles 3-6; second-word Y read in cycle 5.
- Load pulses: first `fifo_switch` high in cycle 8, then cycles 12, 16, … (period exactly 4).
- `y_word` and `v_value_*` change only in the cycle `fifo_switch` is high and are held otherwise.
- `v_rd_en` is at most once per cycle; `y_rd_en` is at most once per window.
- After the final load pulse in cycle T: DRAIN begins at T+1, `done` is high at T+DRAIN_CYCLES, and `feed_enable` is low from T+DRAIN_CYCLES+1.

## Test plan
- Reset held for 3 cycles, mid-stream → all outputs 0, `busy`=0; `start` accepted the next cycle.
- Single EOF word with lanes col 0x0005, 0x8003, 0x0009, EOF → `v_rd_addr` 5 in cycle 3 and 9 in cycle 5; no V read in cycles 4 and 6; only one Y read. `fifo_switch` in cycle 8 with v_values {V[5], 0, V[9], 0}. `done` in cycle 8+DRAIN_CYCLES.
- Three words (third word has EOF in lane 0), base 0x010 → Y reads in cycles 1, 5, 9 at addresses 0x010-0x012. `fifo_switch` in cycles 8, 12, 16 with the matching words; no Y read in cycle 13.
- `y_len`=2, no EOF present → exactly 2 Y reads; `fifo_switch` in cycles 8 and 12; `overrun`=1; `done` in cycle 12+DRAIN_CYCLES.
- `start` pulsed in cycle 6 while busy → no effect on sequence or addresses.
- Back-to-back passes: a second `start` the cycle after `done` → `overrun` cleared, sequence timing identical to the first pass.

Source files
------------

// File: rtl/jacobi_feed_ctrl.sv
// jacobi_feed_ctrl: sequences Y-word and V-value reads so the Y/V multiplier
// feed datapath gets a new Y word and four V values every 4 cycles.
// Each RUN window (ph 0..3) does three things for the staged word:
//   - reads V for lane ph,
//   - prefetches the next Y word in ph2,
//   - at ph0, loads the previous window's word into the output registers.
module jacobi_feed_ctrl #(
  parameter int Y_ADDR_W     = 10,
  parameter int V_ADDR_W     = 10,
  parameter int DRAIN_CYCLES = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [Y_ADDR_W-1:0] y_base,
  input  logic [Y_ADDR_W-1:0] y_len,
  output logic                y_rd_en,
  output logic [Y_ADDR_W-1:0] y_rd_addr,
  input  logic [255:0]        y_rd_data,
  output logic                v_rd_en,
  output logic [V_ADDR_W-1:0] v_rd_addr,
  input  logic [47:0]         v_rd_data,
  output logic [255:0]        y_word,
  output logic [47:0]         v_value_1,
  output logic [47:0]         v_value_2,
  output logic [47:0]         v_value_3,
  output logic [47:0]         v_value_4,
  output logic                fifo_switch,
  output logic                feed_enable,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_FILL, S_RUN, S_DRAIN} state_t;
  state_t state_reg, state_next;

  logic [Y_ADDR_W-1:0] base_reg, len_reg, rd_count_reg;
  logic [1:0]          ph_reg;
  logic [255:0]        stage_reg, cur_reg;
  logic [47:0]         v_buf_reg [3];
  logic [DW-1:0]       drain_cnt_reg;
  logic stage_valid_reg, has_cur_reg, final_reg, stage_ovr_reg;
  logic cur_final_reg, cur_ovr_reg, final_loaded_reg, pend_reg;

  logic [3:0]          lane_eof, lane_diag, lane_normal;
  logic [V_ADDR_W-1:0] lane_addr [4];
  logic                stage_eof, run_st, y_issue, v_issue, load;
  logic [47:0]         lane_val;

  // Per-lane decode of the staged word: EOF marker, diagonal flag, V address.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_eof[gi]  = (stage_reg[255-64*gi -: 3] == 3'b111) &&
                           (stage_reg[252-64*gi -: 61] == '0);
    assign lane_diag[gi] = stage_reg[255-64*gi];
    assign lane_addr[gi] = stage_reg[240-64*gi +: V_ADDR_W];
  end

  // An EOF lane poisons itself and every later lane of the same word.
  always_comb begin
    logic eof_acc;
    eof_acc     = 1'b0;
    lane_normal = '0;
    for (int k = 0; k < 4; k++) begin
      eof_acc        = eof_acc | lane_eof[k];
      lane_normal[k] = ~eof_acc & ~lane_diag[k];
    end
  end

  assign stage_eof = |lane_eof;
  assign run_st    = (state_reg == S_RUN);
  assign y_issue   = run_st && (ph_reg == 2'd2) && stage_valid_reg &&
                     !stage_eof && (rd_count_reg < len_reg);
  assign v_issue   = run_st && stage_valid_reg && lane_normal[ph_reg];
  assign load      = run_st && (ph_reg == 2'd0) && has_cur_reg;
  // Data returning this cycle belongs to last cycle's lane; zero if no read.
  assign lane_val  = pend_reg ? v_rd_data : '0;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and SRAM strobes / status outputs.
  always_comb begin
    state_next  = state_reg;
    y_rd_en     = 1'b0;
    y_rd_addr   = '0;
    v_rd_en     = 1'b0;
    v_rd_addr   = '0;
    feed_enable = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_PRIME;
      end
      S_PRIME: begin
        feed_enable = 1'b1;
        busy        = 1'b1;
        y_rd_en     = 1'b1;
        y_rd_addr   = base_reg + rd_count_reg;
        state_next  = S_FILL;
      end
      S_FILL: begin
        feed_enable = 1'b1;
        busy        = 1'b1;
        state_next  = S_RUN;
      end
      S_RUN: begin
        feed_enable = 1'b1;
        busy        = 1'b1;
        if (y_issue) begin
          y_rd_en   = 1'b1;
          y_rd_addr = base_reg + rd_count_reg;
        end
        if (v_issue) begin
          v_rd_en   = 1'b1;
          v_rd_addr = lane_addr[ph_reg];
        end
        // Leave one cycle after the final load so DRAIN starts after the pulse.
        if (ph_reg == 2'd1 && final_loaded_reg) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        feed_enable = 1'b1;
        busy        = 1'b1;
        if (drain_cnt_reg == DRAIN_LAST) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Stream bookkeeping, staging registers, V buffering and output loads.
  always_ff @(posedge clock) begin
    if (reset) begin
      base_reg         <= '0;
      len_reg          <= '0;
      rd_count_reg     <= '0;
      ph_reg           <= '0;
      stage_reg        <= '0;
      cur_reg          <= '0;
      drain_cnt_reg    <= '0;
      stage_valid_reg  <= 1'b0;
      has_cur_reg      <= 1'b0;
      final_reg        <= 1'b0;
      stage_ovr_reg    <= 1'b0;
      cur_final_reg    <= 1'b0;
      cur_ovr_reg      <= 1'b0;
      final_loaded_reg <= 1'b0;
      pend_reg         <= 1'b0;
      for (int k = 0; k < 3; k++) v_buf_reg[k] <= '0;
      y_word           <= '0;
      v_value_1        <= '0;
      v_value_2        <= '0;
      v_value_3        <= '0;
      v_value_4        <= '0;
      fifo_switch      <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      fifo_switch <= 1'b0;
      pend_reg    <= v_issue;

      if (state_reg == S_IDLE && start) begin
        base_reg     <= y_base;
        len_reg      <= y_len;
        overrun      <= 1'b0;
        rd_count_reg <= '0;
      end else if (y_rd_en) begin
        rd_count_reg <= rd_count_reg + 1'b1;
      end

      if (state_reg == S_DRAIN) drain_cnt_reg <= drain_cnt_reg + 1'b1;
      else                      drain_cnt_reg <= '0;

      if (state_reg == S_FILL) begin
        stage_reg        <= y_rd_data;
        stage_valid_reg  <= 1'b1;
        has_cur_reg      <= 1'b0;
        final_loaded_reg <= 1'b0;
        ph_reg           <= '0;
      end

      if (run_st) begin
        ph_reg <= ph_reg + 2'd1;
        if (ph_reg != 2'd0) v_buf_reg[ph_reg - 2'd1] <= lane_val;
        // No prefetch in ph2 means the staged word ends the stream.
        if (ph_reg == 2'd2) begin
          final_reg     <= !y_issue;
          stage_ovr_reg <= !stage_eof;
        end
        if (ph_reg == 2'd3) begin
          cur_reg         <= stage_reg;
          cur_final_reg   <= final_reg;
          cur_ovr_reg     <= stage_ovr_reg;
          stage_reg       <= y_rd_data;
          stage_valid_reg <= !final_reg;
          has_cur_reg     <= 1'b1;
        end
        if (load) begin
          y_word      <= cur_reg;
          v_value_1   <= v_buf_reg[0];
          v_value_2   <= v_buf_reg[1];
          v_value_3   <= v_buf_reg[2];
          v_value_4   <= lane_val;
          fifo_switch <= 1'b1;
          if (cur_final_reg) begin
            final_loaded_reg <= 1'b1;
            if (cur_ovr_reg) overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jacobi_feed_ctrl.sv
// Self-checking bench for jacobi_feed_ctrl: SRAM models, a pass-level
// expectation model, a per-cycle compare process and literal spot checks.
module tb_jacobi_feed_ctrl;

  localparam int YW    = 10;
  localparam int VW    = 10;
  localparam int D     = 12;
  localparam int N_CYC = 2048;
  localparam logic [63:0] EOF_L = 64'hE000_0000_0000_0000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [YW-1:0] y_base = '0;
  logic [YW-1:0] y_len  = '0;
  logic          y_rd_en;
  logic [YW-1:0] y_rd_addr;
  logic [255:0]  y_rd_data = '0;
  logic          v_rd_en;
  logic [VW-1:0] v_rd_addr;
  logic [47:0]   v_rd_data = '0;
  logic [255:0]  y_word;
  logic [47:0]   v_value_1, v_value_2, v_value_3, v_value_4;
  logic          fifo_switch, feed_enable, busy, done, overrun;

  always #5 clock = ~clock;

  jacobi_feed_ctrl #(.Y_ADDR_W(YW), .V_ADDR_W(VW), .DRAIN_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .start(start), .y_base(y_base), .y_len(y_len),
    .y_rd_en(y_rd_en), .y_rd_addr(y_rd_addr), .y_rd_data(y_rd_data),
    .v_rd_en(v_rd_en), .v_rd_addr(v_rd_addr), .v_rd_data(v_rd_data),
    .y_word(y_word), .v_value_1(v_value_1), .v_value_2(v_value_2),
    .v_value_3(v_value_3), .v_value_4(v_value_4), .fifo_switch(fifo_switch),
    .feed_enable(feed_enable), .busy(busy), .done(done), .overrun(overrun)
  );

  // SRAMs with one-cycle registered read
  logic [255:0] y_mem [1024];
  logic [47:0]  v_mem [1024];
  always @(posedge clock) begin
    if (y_rd_en) y_rd_data <= y_mem[y_rd_addr];
    if (v_rd_en) v_rd_data <= v_mem[v_rd_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // expected behaviour per absolute cycle
  bit            e_yen  [N_CYC];
  logic [YW-1:0] e_yaddr[N_CYC];
  bit            e_ven  [N_CYC];
  logic [VW-1:0] e_vaddr[N_CYC];
  bit            e_fs   [N_CYC];
  bit            e_done [N_CYC];
  bit            e_busy [N_CYC];
  bit            e_ovr  [N_CYC];
  logic [255:0]  e_word [N_CYC];
  logic [47:0]   e_v    [N_CYC][4];
  logic [255:0]  m_word = '0;
  logic [47:0]   m_v [4] = '{default: '0};

  function automatic logic [63:0] ln(input logic [15:0] c, input logic [47:0] v);
    return {c, v};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void clear_from(input int c0);
    for (int c = c0; c < N_CYC; c++) begin
      e_yen[c] = 0; e_yaddr[c] = '0; e_ven[c] = 0; e_vaddr[c] = '0;
      e_fs[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_ovr[c] = 0;
      e_word[c] = '0;
      for (int k = 0; k < 4; k++) e_v[c][k] = '0;
    end
  endfunction

  // Whole-pass model: which words get read, what each load carries, when it ends.
  function automatic void plan(input int s, input logic [YW-1:0] base, input logic [YW-1:0] len);
    int n;
    int t;
    bit eof;
    bit fin;
    logic [255:0] w;
    logic [63:0] lane;
    logic [YW-1:0] a;
    clear_from(s + 1);
    n = 0;
    eof = 0;
    fin = 0;
    while (!fin) begin
      a = base + YW'(n);
      w = y_mem[a];
      e_yen[s+1+4*n] = 1;
      e_yaddr[s+1+4*n] = a;
      eof = 0;
      for (int k = 0; k < 4; k++) begin
        lane = w[255-64*k -: 64];
        if (lane[63:61] == 3'b111 && lane[60:0] == '0) eof = 1;
        if (!eof && !lane[63]) begin
          e_ven[s+3+4*n+k] = 1;
          e_vaddr[s+3+4*n+k] = lane[48 +: VW];
          e_v[s+8+4*n][k] = v_mem[lane[48 +: VW]];
        end
      end
      e_fs[s+8+4*n] = 1;
      e_word[s+8+4*n] = w;
      n++;
      fin = eof || (n == int'(len));
    end
    t = s + 8 + 4*(n-1);
    for (int c = s + 1; c <= t + D; c++) e_busy[c] = 1;
    e_done[t+D] = 1;
    for (int c = t; c < N_CYC; c++) e_ovr[c] = !eof;
  endfunction

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en && cyc < N_CYC) begin
        if (e_fs[cyc]) begin
          m_word = e_word[cyc];
          for (int k = 0; k < 4; k++) m_v[k] = e_v[cyc][k];
        end
        chk("busy", busy, e_busy[cyc]);
        chk("feed_enable", feed_enable, e_busy[cyc]);
        chk("done", done, e_done[cyc]);
        chk("fifo_switch", fifo_switch, e_fs[cyc]);
        chk("overrun", overrun, e_ovr[cyc]);
        chk("y_rd_en", y_rd_en, e_yen[cyc]);
        if (e_yen[cyc]) chk("y_rd_addr", y_rd_addr, e_yaddr[cyc]);
        chk("v_rd_en", v_rd_en, e_ven[cyc]);
        if (e_ven[cyc]) chk("v_rd_addr", v_rd_addr, e_vaddr[cyc]);
        chk("y_word", y_word, m_word);
        chk("v_value_1", v_value_1, m_v[0]);
        chk("v_value_2", v_value_2, m_v[1]);
        chk("v_value_3", v_value_3, m_v[2]);
        chk("v_value_4", v_value_4, m_v[3]);
      end
    end
  end

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    goto_cyc(c);
    @(negedge clock);
  endtask

  task automatic do_start(input logic [YW-1:0] b, input logic [YW-1:0] l, output int s);
    y_base = b;
    y_len  = l;
    start  = 1'b1;
    s      = cyc;
    plan(s, b, l);
    $display("pass: start cycle %0d base 0x%0h len %0d", s, b, l);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int i = 0; i < 1024; i++) begin
      y_mem[i] = '0;
      v_mem[i] = {16'h5A5A, 22'd0, 10'(i)};
    end
    y_mem[10'h000] = {ln(16'h0005, 48'h0A0A_0000_0001), ln(16'h8003, 48'h0A0A_0000_0002),
                      ln(16'h0009, 48'h0A0A_0000_0003), EOF_L};
    y_mem[10'h010] = {ln(16'h0001, 48'h1), ln(16'h0002, 48'h2), ln(16'h0003, 48'h3), ln(16'h0004, 48'h4)};
    y_mem[10'h011] = {ln(16'h8001, 48'h5), ln(16'h0010, 48'h6), ln(16'h0011, 48'h7),
                      64'hE000_0000_0000_0001};
    y_mem[10'h012] = {EOF_L, ln(16'h0007, 48'h8), ln(16'h0008, 48'h9), ln(16'h0009, 48'hA)};
    y_mem[10'h020] = {ln(16'h0421, 48'hB), ln(16'h0022, 48'hC), ln(16'h0023, 48'hD), ln(16'h0024, 48'hE)};
    y_mem[10'h021] = {ln(16'h0025, 48'hF), ln(16'h0026, 48'h10), ln(16'h0027, 48'h11), ln(16'h0028, 48'h12)};
    y_mem[10'h022] = {ln(16'h0029, 48'h13), ln(16'h002A, 48'h14), ln(16'h002B, 48'h15), ln(16'h002C, 48'h16)};
    clear_from(0);

    // initial reset for 3 cycles
    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    at_neg(cyc);
    chk("reset busy", busy, 1'b0);
    chk("reset y_word", y_word, 256'h0);
    chk("reset overrun", overrun, 1'b0);

    // single EOF word
    goto_cyc(cyc + 1);
    do_start(10'h000, 10'd5, s);
    at_neg(s + 3);
    chk("A v_rd_addr c3", v_rd_addr, 10'd5);
    at_neg(s + 4);
    chk("A no v read c4", v_rd_en, 1'b0);
    at_neg(s + 5);
    chk("A v_rd_addr c5", v_rd_addr, 10'd9);
    chk("A no y read c5", y_rd_en, 1'b0);
    at_neg(s + 6);
    chk("A no v read c6", v_rd_en, 1'b0);
    at_neg(s + 8);
    chk("A fifo_switch c8", fifo_switch, 1'b1);
    chk("A v_value_1", v_value_1, 48'h5A5A_0000_0005);
    chk("A v_value_2", v_value_2, 48'h0);
    chk("A v_value_3", v_value_3, 48'h5A5A_0000_0009);
    chk("A v_value_4", v_value_4, 48'h0);
    at_neg(s + 8 + D);
    chk("A done", done, 1'b1);
    at_neg(s + 9 + D);
    chk("A feed_enable low", feed_enable, 1'b0);

    // three words, EOF in lane 0 of the third; stray start while busy
    goto_cyc(cyc + 2);
    do_start(10'h010, 10'd10, s);
    goto_cyc(s + 6);
    y_base = 10'h3F0;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
    y_base = 10'h010;
    at_neg(s + 9);
    chk("B y_rd_en c9", y_rd_en, 1'b1);
    chk("B y_rd_addr c9", y_rd_addr, 10'h012);
    at_neg(s + 13);
    chk("B no y read c13", y_rd_en, 1'b0);
    at_neg(s + 16);
    chk("B fifo_switch c16", fifo_switch, 1'b1);
    chk("B y_word c16", y_word, {EOF_L, ln(16'h0007, 48'h8), ln(16'h0008, 48'h9), ln(16'h0009, 48'hA)});
    goto_cyc(s + 16 + D + 2);

    // y_len = 2 without EOF -> overrun, then back-to-back pass
    do_start(10'h020, 10'd2, s);
    at_neg(s + 3);
    chk("C v_rd_addr trunc", v_rd_addr, 10'h021);
    at_neg(s + 12);
    chk("C fifo_switch c12", fifo_switch, 1'b1);
    chk("C v_value_1", v_value_1, 48'h5A5A_0000_0025);
    at_neg(s + 12 + D);
    chk("C done", done, 1'b1);
    chk("C overrun", overrun, 1'b1);
    goto_cyc(s + 13 + D);
    do_start(10'h000, 10'd5, s);
    at_neg(s + 1);
    chk("E overrun cleared", overrun, 1'b0);
    at_neg(s + 8);
    chk("E fifo_switch c8", fifo_switch, 1'b1);
    goto_cyc(s + 8 + D + 2);

    // reset mid-stream, held 3 cycles, then immediate restart
    do_start(10'h010, 10'd10, s);
    goto_cyc(s + 10);
    reset  = 1'b1;
    chk_en = 1'b0;
    clear_from(cyc);
    m_word = '0;
    for (int k = 0; k < 4; k++) m_v[k] = '0;
    @(posedge clock);
    #1;
    chk_en = 1'b1;
    at_neg(s + 12);
    chk("R busy", busy, 1'b0);
    chk("R y_word", y_word, 256'h0);
    chk("R v_value_1", v_value_1, 48'h0);
    chk("R feed_enable", feed_enable, 1'b0);
    goto_cyc(s + 13);
    reset = 1'b0;
    do_start(10'h020, 10'd2, s);
    at_neg(s + 1);
    chk("R restart y_rd_en", y_rd_en, 1'b1);
    chk("R restart y_rd_addr", y_rd_addr, 10'h020);
    goto_cyc(s + 12 + D + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
